// File: rtl/cva6_store_unit_if.sv
// Bundle of the store unit's issue, writeback, commit and D$ write-port signals.
// valid/ready: a store op transfers when valid_i & ready_o are high at the rising edge;
// commit transfers on commit_i & commit_ready_o; a D$ write completes on req_o & gnt_i.
interface cva6_store_unit_if #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int TID_W = 4
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [TID_W-1:0] trans_id_i;
  logic [AW-1:0]    addr_i;
  logic [DW-1:0]    data_i;
  logic [1:0]       size_i;
  logic             valid_o;
  logic [TID_W-1:0] trans_id_o;
  logic             ex_valid_o;
  logic             commit_i;
  logic             commit_ready_o;
  logic             req_o;
  logic [AW-1:0]    addr_o;
  logic [DW-1:0]    wdata_o;
  logic [DW/8-1:0]  be_o;
  logic             gnt_i;
  logic             no_st_pending_o;

  modport slave (
    input  flush_i, valid_i, trans_id_i, addr_i, data_i, size_i, commit_i, gnt_i,
    output ready_o, valid_o, trans_id_o, ex_valid_o, commit_ready_o,
           req_o, addr_o, wdata_o, be_o, no_st_pending_o
  );

  modport master (
    output flush_i, valid_i, trans_id_i, addr_i, data_i, size_i, commit_i, gnt_i,
    input  ready_o, valid_o, trans_id_o, ex_valid_o, commit_ready_o,
           req_o, addr_o, wdata_o, be_o, no_st_pending_o
  );
endinterface

// File: rtl/cva6_store_unit.sv
// Store path: alignment check, one-cycle writeback, speculative queue released by
// commit into a commit queue that drains to the D$ write port.
module cva6_store_unit #(
  parameter int SPEC_DEPTH   = 4,
  parameter int COMMIT_DEPTH = 4,
  parameter int AW           = 32,
  parameter int DW           = 64,
  parameter int TID_W        = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  cva6_store_unit_if.slave  bus
);
  localparam int SPW = $clog2(SPEC_DEPTH);
  localparam int SCW = SPW + 1;
  localparam int CPW = $clog2(COMMIT_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int BW  = DW / 8;
  localparam logic [SCW-1:0] SPEC_FULL   = SCW'(SPEC_DEPTH);
  localparam logic [CCW-1:0] COMMIT_FULL = CCW'(COMMIT_DEPTH);

  logic [AW-1:0]  spec_addr_q  [SPEC_DEPTH];
  logic [DW-1:0]  spec_wdata_q [SPEC_DEPTH];
  logic [BW-1:0]  spec_be_q    [SPEC_DEPTH];
  logic [SPW-1:0] spec_wr_q, spec_rd_q;
  logic [SCW-1:0] spec_cnt_q;

  logic [AW-1:0]  cm_addr_q  [COMMIT_DEPTH];
  logic [DW-1:0]  cm_wdata_q [COMMIT_DEPTH];
  logic [BW-1:0]  cm_be_q    [COMMIT_DEPTH];
  logic [CPW-1:0] cm_wr_q, cm_rd_q;
  logic [CCW-1:0] cm_cnt_q;

  logic             wb_valid_q, wb_ex_q;
  logic [TID_W-1:0] wb_tid_q;

  logic           spec_full, spec_empty, cm_full, cm_empty;
  logic           ready, accept, misaligned, enq, commit_fire, mem_pop;
  logic [BW-1:0]  be_raw, be_new;
  logic [DW-1:0]  wdata_new;

  always_comb begin
    spec_full  = (spec_cnt_q == SPEC_FULL);
    spec_empty = (spec_cnt_q == '0);
    cm_full    = (cm_cnt_q == COMMIT_FULL);
    cm_empty   = (cm_cnt_q == '0);
    ready      = ~spec_full;
    accept     = bus.valid_i & ready & ~bus.flush_i;

    misaligned = 1'b0;
    be_raw     = '0;
    case (bus.size_i)
      2'd0: begin misaligned = 1'b0;               be_raw = BW'(8'h01); end
      2'd1: begin misaligned = bus.addr_i[0];      be_raw = BW'(8'h03); end
      2'd2: begin misaligned = |bus.addr_i[1:0];   be_raw = BW'(8'h0F); end
      default: begin misaligned = |bus.addr_i[2:0]; be_raw = BW'(8'hFF); end
    endcase

    be_new      = be_raw << bus.addr_i[2:0];
    wdata_new   = bus.data_i << {bus.addr_i[2:0], 3'b000};
    enq         = accept & ~misaligned;
    commit_fire = bus.commit_i & ~spec_empty & ~cm_full;
    mem_pop     = ~cm_empty & bus.gnt_i;
  end

  // Flush discards speculative entries but a same-cycle commit still moves the head out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_wr_q  <= '0;
      spec_rd_q  <= '0;
      spec_cnt_q <= '0;
    end else if (bus.flush_i) begin
      spec_wr_q  <= '0;
      spec_rd_q  <= '0;
      spec_cnt_q <= '0;
    end else begin
      if (enq)         spec_wr_q <= spec_wr_q + SPW'(1);
      if (commit_fire) spec_rd_q <= spec_rd_q + SPW'(1);
      if (enq && !commit_fire)      spec_cnt_q <= spec_cnt_q + SCW'(1);
      else if (!enq && commit_fire) spec_cnt_q <= spec_cnt_q - SCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      spec_addr_q[spec_wr_q]  <= {bus.addr_i[AW-1:3], 3'b000};
      spec_wdata_q[spec_wr_q] <= wdata_new;
      spec_be_q[spec_wr_q]    <= be_new;
    end
    if (commit_fire) begin
      cm_addr_q[cm_wr_q]  <= spec_addr_q[spec_rd_q];
      cm_wdata_q[cm_wr_q] <= spec_wdata_q[spec_rd_q];
      cm_be_q[cm_wr_q]    <= spec_be_q[spec_rd_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cm_wr_q  <= '0;
      cm_rd_q  <= '0;
      cm_cnt_q <= '0;
    end else begin
      if (commit_fire) cm_wr_q <= cm_wr_q + CPW'(1);
      if (mem_pop)     cm_rd_q <= cm_rd_q + CPW'(1);
      if (commit_fire && !mem_pop)      cm_cnt_q <= cm_cnt_q + CCW'(1);
      else if (!commit_fire && mem_pop) cm_cnt_q <= cm_cnt_q - CCW'(1);
    end
  end

  // accept is already low under flush, so the following writeback slot stays empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_ex_q    <= 1'b0;
      wb_tid_q   <= '0;
    end else begin
      wb_valid_q <= accept;
      wb_ex_q    <= accept & misaligned;
      if (accept) wb_tid_q <= bus.trans_id_i;
    end
  end

  assign bus.ready_o         = ready;
  assign bus.valid_o         = wb_valid_q;
  assign bus.trans_id_o      = wb_tid_q;
  assign bus.ex_valid_o      = wb_ex_q;
  assign bus.commit_ready_o  = ~spec_empty & ~cm_full;
  assign bus.req_o           = ~cm_empty;
  assign bus.addr_o          = cm_addr_q[cm_rd_q];
  assign bus.wdata_o         = cm_wdata_q[cm_rd_q];
  assign bus.be_o            = cm_be_q[cm_rd_q];
  assign bus.no_st_pending_o = spec_empty & cm_empty;
endmodule

// File: tb/tb_cva6_store_unit.sv
// Directed bench for cva6_store_unit: writeback, alignment, fill, flush, wrap ordering.
module tb_cva6_store_unit;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TID_W = 4;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  cva6_store_unit_if #(.AW(AW), .DW(DW), .TID_W(TID_W)) bus ();

  cva6_store_unit #(
    .SPEC_DEPTH(4), .COMMIT_DEPTH(4), .AW(AW), .DW(DW), .TID_W(TID_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle_inputs();
    bus.flush_i    = 1'b0;
    bus.valid_i    = 1'b0;
    bus.trans_id_i = '0;
    bus.addr_i     = '0;
    bus.data_i     = '0;
    bus.size_i     = 2'd0;
    bus.commit_i   = 1'b0;
    bus.gnt_i      = 1'b0;
  endtask

  task automatic set_store(input logic [TID_W-1:0] tid, input logic [AW-1:0] addr,
                           input logic [1:0] size, input logic [DW-1:0] data);
    bus.valid_i    = 1'b1;
    bus.trans_id_i = tid;
    bus.addr_i     = addr;
    bus.size_i     = size;
    bus.data_i     = data;
  endtask

  // one-cycle store pulse; returns at the negedge after the accepting edge
  task automatic do_store(input logic [TID_W-1:0] tid, input logic [AW-1:0] addr,
                          input logic [1:0] size, input logic [DW-1:0] data);
    set_store(tid, addr, size, data);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit_i = 1'b1;
    @(negedge clk);
    bus.commit_i = 1'b0;
  endtask

  task automatic pulse_gnt();
    bus.gnt_i = 1'b1;
    @(negedge clk);
    bus.gnt_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %0h exp 0", bus.valid_o); else passed++;
    total++; if (bus.trans_id_o !== 4'd0) $display("FAIL reset_tid got %0h exp 0", bus.trans_id_o); else passed++;
    total++; if (bus.ex_valid_o !== 1'b0) $display("FAIL reset_ex got %0h exp 0", bus.ex_valid_o); else passed++;
    total++; if (bus.req_o !== 1'b0) $display("FAIL reset_req got %0h exp 0", bus.req_o); else passed++;
    total++; if (bus.ready_o !== 1'b1) $display("FAIL reset_ready got %0h exp 1", bus.ready_o); else passed++;
    total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL reset_commit_ready got %0h exp 0", bus.commit_ready_o); else passed++;
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL reset_no_pending got %0h exp 1", bus.no_st_pending_o); else passed++;
  endtask

  task automatic test_aligned_word();
    do_store(4'd3, 32'h1004, 2'd2, 64'hDEADBEEF);
    total++; if (bus.valid_o !== 1'b1) $display("FAIL word_wb_valid got %0h exp 1", bus.valid_o); else passed++;
    total++; if (bus.trans_id_o !== 4'd3) $display("FAIL word_wb_tid got %0h exp 3", bus.trans_id_o); else passed++;
    total++; if (bus.ex_valid_o !== 1'b0) $display("FAIL word_wb_ex got %0h exp 0", bus.ex_valid_o); else passed++;
    total++; if (bus.commit_ready_o !== 1'b1) $display("FAIL word_commit_ready got %0h exp 1", bus.commit_ready_o); else passed++;
    total++; if (bus.no_st_pending_o !== 1'b0) $display("FAIL word_pending got %0h exp 0", bus.no_st_pending_o); else passed++;
    pulse_commit();
    total++; if (bus.valid_o !== 1'b0) $display("FAIL word_wb_pulse got %0h exp 0", bus.valid_o); else passed++;
    total++; if (bus.trans_id_o !== 4'd3) $display("FAIL word_tid_hold got %0h exp 3", bus.trans_id_o); else passed++;
    total++; if (bus.req_o !== 1'b1) $display("FAIL word_req got %0h exp 1", bus.req_o); else passed++;
    total++; if (bus.addr_o !== 32'h1000) $display("FAIL word_addr got %0h exp 1000", bus.addr_o); else passed++;
    total++; if (bus.be_o !== 8'hF0) $display("FAIL word_be got %0h exp f0", bus.be_o); else passed++;
    total++; if (bus.wdata_o !== 64'hDEADBEEF_00000000) $display("FAIL word_wdata got %0h exp deadbeef00000000", bus.wdata_o); else passed++;
    pulse_gnt();
    total++; if (bus.req_o !== 1'b0) $display("FAIL word_req_after_gnt got %0h exp 0", bus.req_o); else passed++;
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL word_pending_after_gnt got %0h exp 1", bus.no_st_pending_o); else passed++;
  endtask

  task automatic test_misaligned();
    logic [AW-1:0]    addrs [3];
    logic [1:0]       sizes [3];
    logic [TID_W-1:0] tids  [3];
    addrs = '{32'h1001, 32'h1002, 32'h1004};
    sizes = '{2'd1, 2'd2, 2'd3};
    tids  = '{4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 3; i++) begin
      do_store(tids[i], addrs[i], sizes[i], 64'h1234);
      total++; if (bus.valid_o !== 1'b1) $display("FAIL mis%0d_wb_valid got %0h exp 1", i, bus.valid_o); else passed++;
      total++; if (bus.trans_id_o !== tids[i]) $display("FAIL mis%0d_wb_tid got %0h exp %0h", i, bus.trans_id_o, tids[i]); else passed++;
      total++; if (bus.ex_valid_o !== 1'b1) $display("FAIL mis%0d_wb_ex got %0h exp 1", i, bus.ex_valid_o); else passed++;
      total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL mis%0d_pending got %0h exp 1", i, bus.no_st_pending_o); else passed++;
      total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL mis%0d_commit_ready got %0h exp 0", i, bus.commit_ready_o); else passed++;
    end
    @(negedge clk);
    total++; if (bus.ex_valid_o !== 1'b0) $display("FAIL mis_ex_clear got %0h exp 0", bus.ex_valid_o); else passed++;
  endtask

  task automatic test_sizes();
    logic [AW-1:0] addrs  [4];
    logic [1:0]    sizes  [4];
    logic [DW-1:0] datas  [4];
    logic [AW-1:0] e_addr [4];
    logic [7:0]    e_be   [4];
    logic [DW-1:0] e_wd   [4];
    addrs  = '{32'h2003, 32'h2006, 32'h2008, 32'h2000};
    sizes  = '{2'd0, 2'd1, 2'd3, 2'd2};
    datas  = '{64'hAB, 64'h1234, 64'h0123456789ABCDEF, 64'hCAFEF00D};
    e_addr = '{32'h2000, 32'h2000, 32'h2008, 32'h2000};
    e_be   = '{8'h08, 8'hC0, 8'hFF, 8'h0F};
    e_wd   = '{64'h00000000_AB000000, 64'h1234_0000_0000_0000, 64'h0123456789ABCDEF, 64'h00000000_CAFEF00D};
    for (int i = 0; i < 4; i++) begin
      do_store(TID_W'(i + 1), addrs[i], sizes[i], datas[i]);
      total++; if (bus.ex_valid_o !== 1'b0) $display("FAIL size%0d_ex got %0h exp 0", i, bus.ex_valid_o); else passed++;
      pulse_commit();
      total++; if (bus.addr_o !== e_addr[i]) $display("FAIL size%0d_addr got %0h exp %0h", i, bus.addr_o, e_addr[i]); else passed++;
      total++; if (bus.be_o !== e_be[i]) $display("FAIL size%0d_be got %0h exp %0h", i, bus.be_o, e_be[i]); else passed++;
      total++; if (bus.wdata_o !== e_wd[i]) $display("FAIL size%0d_wdata got %0h exp %0h", i, bus.wdata_o, e_wd[i]); else passed++;
      pulse_gnt();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      set_store(TID_W'(i), AW'(32'h3000 + 8 * i), 2'd3, DW'(i));
      @(negedge clk);
      total++; if (bus.valid_o !== (i < 4)) $display("FAIL fill%0d_wb_valid got %0h exp %0h", i, bus.valid_o, (i < 4)); else passed++;
      total++; if (bus.trans_id_o !== TID_W'((i < 4) ? i : 3)) $display("FAIL fill%0d_wb_tid got %0h exp %0h", i, bus.trans_id_o, (i < 4) ? i : 3); else passed++;
      total++; if (bus.ready_o !== (i < 3)) $display("FAIL fill%0d_ready got %0h exp %0h", i, bus.ready_o, (i < 3)); else passed++;
    end
    bus.valid_i = 1'b0;
    bus.commit_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.commit_i = 1'b0;
    total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL fill_commit_ready got %0h exp 0", bus.commit_ready_o); else passed++;
    total++; if (bus.ready_o !== 1'b1) $display("FAIL fill_ready_after_commit got %0h exp 1", bus.ready_o); else passed++;
    total++; if (bus.req_o !== 1'b1) $display("FAIL fill_req got %0h exp 1", bus.req_o); else passed++;
    do_store(4'd10, 32'h3100, 2'd3, 64'hA);
    total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL fill_commit_full got %0h exp 0", bus.commit_ready_o); else passed++;
    pulse_commit();
    bus.gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.addr_o !== AW'(32'h3000 + 8 * k)) $display("FAIL drain%0d_addr got %0h exp %0h", k, bus.addr_o, 32'h3000 + 8 * k); else passed++;
      total++; if (bus.wdata_o !== DW'(k)) $display("FAIL drain%0d_wdata got %0h exp %0h", k, bus.wdata_o, k); else passed++;
      @(negedge clk);
    end
    bus.gnt_i = 1'b0;
    total++; if (bus.req_o !== 1'b0) $display("FAIL drain_empty_req got %0h exp 0", bus.req_o); else passed++;
    total++; if (bus.commit_ready_o !== 1'b1) $display("FAIL drain_commit_ready got %0h exp 1", bus.commit_ready_o); else passed++;
    pulse_commit();
    total++; if (bus.addr_o !== 32'h3100) $display("FAIL late_addr got %0h exp 3100", bus.addr_o); else passed++;
    total++; if (bus.wdata_o !== 64'hA) $display("FAIL late_wdata got %0h exp a", bus.wdata_o); else passed++;
    pulse_gnt();
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL fill_end_pending got %0h exp 1", bus.no_st_pending_o); else passed++;
  endtask

  task automatic test_flush();
    do_store(4'd1, 32'h4000, 2'd3, 64'h11);
    do_store(4'd2, 32'h4008, 2'd3, 64'h22);
    do_store(4'd3, 32'h4010, 2'd3, 64'h33);
    pulse_commit();
    bus.flush_i = 1'b1;
    set_store(4'd9, 32'h5000, 2'd3, 64'h99);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    total++; if (bus.valid_o !== 1'b0) $display("FAIL flush_wb_valid got %0h exp 0", bus.valid_o); else passed++;
    total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL flush_commit_ready got %0h exp 0", bus.commit_ready_o); else passed++;
    total++; if (bus.req_o !== 1'b1) $display("FAIL flush_req got %0h exp 1", bus.req_o); else passed++;
    total++; if (bus.addr_o !== 32'h4000) $display("FAIL flush_addr got %0h exp 4000", bus.addr_o); else passed++;
    total++; if (bus.wdata_o !== 64'h11) $display("FAIL flush_wdata got %0h exp 11", bus.wdata_o); else passed++;
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) $display("FAIL flush_no_late_wb got %0h exp 0", bus.valid_o); else passed++;
    pulse_gnt();
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL flush_pending got %0h exp 1", bus.no_st_pending_o); else passed++;
    do_store(4'd4, 32'h4100, 2'd3, 64'h44);
    do_store(4'd5, 32'h4108, 2'd3, 64'h55);
    bus.flush_i  = 1'b1;
    bus.commit_i = 1'b1;
    @(negedge clk);
    bus.flush_i  = 1'b0;
    bus.commit_i = 1'b0;
    total++; if (bus.req_o !== 1'b1) $display("FAIL flcm_req got %0h exp 1", bus.req_o); else passed++;
    total++; if (bus.addr_o !== 32'h4100) $display("FAIL flcm_addr got %0h exp 4100", bus.addr_o); else passed++;
    total++; if (bus.commit_ready_o !== 1'b0) $display("FAIL flcm_commit_ready got %0h exp 0", bus.commit_ready_o); else passed++;
    pulse_gnt();
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL flcm_pending got %0h exp 1", bus.no_st_pending_o); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr_q [$];
    logic [7:0]    exp_be_q   [$];
    logic [DW-1:0] exp_wd_q   [$];
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [7:0]    be;
    logic [2:0]    off;
    logic [1:0]    size;
    int            popped;
    popped = 0;
    bus.commit_i = 1'b1;
    bus.gnt_i    = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (bus.req_o === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          total++; $display("FAIL b2b_extra_req got addr %0h exp none", bus.addr_o);
        end else begin
          total++; if (bus.addr_o !== exp_addr_q[0]) $display("FAIL b2b%0d_addr got %0h exp %0h", popped, bus.addr_o, exp_addr_q[0]); else passed++;
          total++; if (bus.be_o !== exp_be_q[0]) $display("FAIL b2b%0d_be got %0h exp %0h", popped, bus.be_o, exp_be_q[0]); else passed++;
          total++; if (bus.wdata_o !== exp_wd_q[0]) $display("FAIL b2b%0d_wdata got %0h exp %0h", popped, bus.wdata_o, exp_wd_q[0]); else passed++;
          void'(exp_addr_q.pop_front());
          void'(exp_be_q.pop_front());
          void'(exp_wd_q.pop_front());
        end
        popped++;
      end
      if (c >= 1 && c <= 12) begin
        total++; if (bus.valid_o !== 1'b1 || bus.trans_id_o !== TID_W'(c - 1)) $display("FAIL b2b_wb%0d got v=%0h id=%0h exp v=1 id=%0h", c - 1, bus.valid_o, bus.trans_id_o, c - 1); else passed++;
      end
      if (c < 12) begin
        size = 2'(c % 4);
        case (size)
          2'd0: begin off = 3'(c % 8);       mask = 64'hFF;               be = 8'h01; end
          2'd1: begin off = 3'(2 * (c % 4)); mask = 64'hFFFF;             be = 8'h03; end
          2'd2: begin off = 3'(4 * (c % 2)); mask = 64'hFFFF_FFFF;        be = 8'h0F; end
          default: begin off = 3'd0;         mask = 64'hFFFF_FFFF_FFFF_FFFF; be = 8'hFF; end
        endcase
        data = (64'h0102_0304_0506_0708 * DW'(c + 1)) & mask;
        set_store(TID_W'(c), AW'(32'h6000 + 16 * c) + AW'(off), size, data);
        exp_addr_q.push_back(AW'(32'h6000 + 16 * c));
        exp_be_q.push_back(be << off);
        exp_wd_q.push_back(data << (8 * off));
      end else begin
        bus.valid_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.commit_i = 1'b0;
    bus.gnt_i    = 1'b0;
    total++; if (popped !== 12) $display("FAIL b2b_write_count got %0d exp 12", popped); else passed++;
    total++; if (bus.no_st_pending_o !== 1'b1) $display("FAIL b2b_pending got %0h exp 1", bus.no_st_pending_o); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_aligned_word();
    test_misaligned();
    test_sizes();
    test_fill();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cva6_store_unit.md
Name: cva6_store_unit

Overview:
- Store path of the load/store unit. Accepts issued store ops and checks alignment.
- Writes back a result (trans_id, exception flag) one cycle later.
- Holds accepted stores in a speculative queue until the commit stage releases them, then moves them to a commit queue that drains to the data-cache write port.
- Sits between the issue/LSU dispatch logic, the commit stage and the D$ store port.

Parameters:
- SPEC_DEPTH, 4, speculative queue entries (power of 2, >=2)
- COMMIT_DEPTH, 4, commit queue entries (power of 2, >=2)
- AW, 32, physical address width
- DW, 64, store data width (byte enables DW/8 = 8)
- TID_W, 4, transaction id width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill all speculative (uncommitted) stores and pending writeback
- valid_i  in  1  store op presented
- ready_o  out  1  store op can be accepted
- trans_id_i  in  TID_W  scoreboard id of presented op
- addr_i  in  AW  store byte address
- data_i  in  DW  store data, LSB-aligned
- size_i  in  2  0=byte 1=half 2=word 3=dword
- valid_o  out  1  writeback valid
- trans_id_o  out  TID_W  id of written-back op
- ex_valid_o  out  1  writeback carries store-address-misaligned exception
- commit_i  in  1  commit oldest speculative store
- commit_ready_o  out  1  commit can be taken
- req_o  out  1  D$ write request
- addr_o  out  AW  D$ address, addr[2:0] forced 0
- wdata_o  out  DW  D$ lane-aligned data
- be_o  out  DW/8  D$ byte enables
- gnt_i  in  1  D$ grant, pops commit queue head
- no_st_pending_o  out  1  both queues empty

Behaviour:
- Reset (async, rst_ni=0): both queues empty, valid_o=0, trans_id_o=0, ex_valid_o=0, req_o=0, no_st_pending_o=1.
- Acceptance:
  - accept = valid_i & ready_o & ~flush_i.
  - ready_o = ~spec_full; registered state only, no same-cycle bypass from commit_i.
  - valid_i while ready_o=0 is ignored, with no writeback.
- Alignment: misaligned when size=1 & addr[0]; size=2 & addr[1:0]!=0; size=3 & addr[2:0]!=0. Byte stores are never misaligned.
- Accepted and aligned:
  - Entry enqueued into the speculative queue.
  - be = ((1<<(1<<size))-1) << addr[2:0].
  - wdata = data_i << (8*addr[2:0]), truncated to DW.
  - addr stored with [2:0] cleared.
- Accepted and misaligned: nothing enqueued.
- Writeback timing: the cycle after accept, valid_o=1 and trans_id_o=trans_id_i. ex_valid_o=1 if misaligned, else 0. valid_o is a single-cycle pulse per accepted op; back-to-back accepts give consecutive pulses.
- trans_id_o holds its last value when valid_o=0.
- Commit:
  - commit_ready_o = spec_nonempty & ~commit_full.
  - commit_i & commit_ready_o moves the spec head to the commit tail in the same edge.
  - commit_i without commit_ready_o is ignored.
- Memory:
  - req_o = commit_nonempty; addr_o/wdata_o/be_o show the commit head.
  - req_o & gnt_i pops the head. Push and pop in the same cycle is legal, and the count is unchanged.
- Flush:
  - flush_i empties the speculative queue, blocks acceptance that cycle, and forces valid_o=0 the next cycle.
  - The commit queue is never flushed.
  - flush_i & commit_i in the same cycle: the commit is performed (head moves to the commit queue), then the remaining speculative entries are discarded.
- Queues: circular FIFOs with wrap-around pointers. Full or empty is derived from an explicit count (0..DEPTH). FIFO order is preserved across wrap.
- no_st_pending_o = spec_empty & commit_empty, registered-state based.

Test Plan:
- Reset then idle: rst_ni=0 for 5 cycles, then 1 -> valid_o=0, trans_id_o=0, req_o=0, ready_o=1, no_st_pending_o=1.
- Aligned word store: trans_id_i=3, addr=0x1004, size=2, data=0xDEADBEEF.
  - Next cycle: valid_o=1, trans_id_o=3, ex_valid_o=0.
  - After commit_i: req_o=1, addr_o=0x1000, be_o=0xF0, wdata_o=0xDEADBEEF_00000000. gnt_i=1 -> no_st_pending_o=1.
- Misaligned half: addr=0x1001, size=1, trans_id_i=7 -> next cycle valid_o=1, trans_id_o=7, ex_valid_o=1. Queue stays empty.
- Fill: valid_i held 10 cycles with ids 0..9, no commit.
  - ids 0..3 written back; ready_o=0 from the cycle after the 4th accept.
  - ids 4..9 dropped with no valid_o.
  - 4 commits with gnt_i=0 -> commit queue full, commit_ready_o=0.
- Flush: 3 stores accepted, 1 committed, then flush_i.
  - Spec queue empty; committed store still issues req_o.
  - Store presented during the flush cycle is not written back.
- Wrap/order: 12 stores with ids 0..11, each committed and granted in a steady stream -> D$ writes appear in id order 0..11 with correct be_o/wdata_o.
